cmos_frame_buf_ctrl: RTL and testbench

Capture sequencer between the RGB565 CMOS capture stage and the frame-buffer write port. Arms on software request and aligns to a frame start. Buffers pixels through a small FIFO against write-port back-pressure and generates ping-pong bank write addresses. Validates frame geometry and publishes the last good bank to the display side.

---
 rtl/cmos_frame_buf_ctrl_if.sv | 50 +++++
 rtl/cmos_frame_buf_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_cmos_frame_buf_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmos_frame_buf_ctrl_if.sv
// cmos_frame_buf_ctrl_if
// Bundles the capture-side inputs, the frame-buffer write port and the
// control/status lines of the capture sequencer.
//   master : the sequencer (drives the write port and status)
//   slave  : the surrounding system (sensor, software, frame-buffer port)

interface cmos_frame_buf_ctrl_if #(
  parameter int ADDR_W = 24
);

  // software control
  logic              cap_start;
  logic              cap_stop;

  // CMOS capture stage
  logic              cmos_frame_vsync;
  logic              cmos_frame_href;
  logic              cmos_frame_clken;
  logic [15:0]       cmos_frame_data;

  // frame-buffer write port
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  // display-side status
  logic              disp_bank;
  logic              disp_valid;
  logic              frame_done;
  logic              frame_err;
  logic              busy;

  modport master (
    input  cap_start, cap_stop,
    input  cmos_frame_vsync, cmos_frame_href, cmos_frame_clken, cmos_frame_data,
    output wr_en, wr_addr, wr_data,
    input  wr_ready,
    output disp_bank, disp_valid, frame_done, frame_err, busy
  );

  modport slave (
    output cap_start, cap_stop,
    output cmos_frame_vsync, cmos_frame_href, cmos_frame_clken, cmos_frame_data,
    input  wr_en, wr_addr, wr_data,
    output wr_ready,
    input  disp_bank, disp_valid, frame_done, frame_err, busy
  );

endinterface

// File: rtl/cmos_frame_buf_ctrl.sv
// cmos_frame_buf_ctrl
// Capture sequencer between the RGB565 CMOS capture stage and the frame-buffer
// write port. Arms on cap_start, aligns to a vsync rising edge, buffers pixels
// in a small FIFO against write-port back-pressure, writes each frame into one
// of two ping-pong banks and publishes the newest good bank to the display.
//
// Optional feature: define CMOS_SIZE_CHECK_EN to enable per-line pixel and
// per-frame line counting; any geometry mismatch discards the frame. Without
// it, a frame is discarded only on FIFO overflow.

module cmos_frame_buf_ctrl #(
  parameter int IMG_HDISP  = 640,
  parameter int IMG_VDISP  = 480,
  parameter int ADDR_W     = 24,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  cmos_pclk,
  input  logic                  rst,
  cmos_frame_buf_ctrl_if.master bus
);

  localparam int FRAME_PIX = IMG_HDISP * IMG_VDISP;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    CAPTURE,
    FLUSH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_vs_d;
  logic               w_vs_rise;
  logic               w_vs_fall;

  logic [15:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_empty;
  logic               w_full;
  logic               w_push_req;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic               w_wr_en;

  logic               r_ovf;
  logic               r_stop_pending;
  logic               r_wbank;
  logic               r_disp_bank;
  logic               r_disp_valid;
  logic               r_frame_done;
  logic               r_frame_err;
  logic [ADDR_W-1:0]  r_wr_addr;

  logic               w_load;
  logic               w_eval;
  logic               w_geo_bad;
  logic               w_good;

  // ---------------------------------------------------------------------------
  // vsync edge detection
  // ---------------------------------------------------------------------------
  assign w_vs_rise = bus.cmos_frame_vsync & ~r_vs_d;
  assign w_vs_fall = ~bus.cmos_frame_vsync & r_vs_d;

  // Register the previous vsync level for edge detection.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) r_vs_d <= 1'b0;
    else     r_vs_d <= bus.cmos_frame_vsync;
  end

  // ---------------------------------------------------------------------------
  // sequencer FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic plus frame-start (load) and frame-evaluate strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_eval      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.cap_start && !bus.cap_stop) w_state_nxt = WAIT_VS;
      end
      WAIT_VS: begin
        if (bus.cap_stop) begin
          w_state_nxt = IDLE;
        end else if (w_vs_rise) begin
          w_state_nxt = CAPTURE;
          w_load      = 1'b1;
        end
      end
      CAPTURE: begin
        if (w_vs_fall) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        // The FIFO output is the only storage between sensor and write
        // port, so an empty FIFO means nothing is still in flight.
        if (w_empty) begin
          w_eval      = 1'b1;
          w_state_nxt = (r_stop_pending || bus.cap_stop) ? IDLE : WAIT_VS;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A stop request arriving mid-frame is deferred until the frame finishes.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      r_stop_pending <= 1'b0;
    end else if (r_state != IDLE && w_state_nxt == IDLE) begin
      r_stop_pending <= 1'b0;
    end else if (bus.cap_stop && (r_state == CAPTURE || r_state == FLUSH)) begin
      r_stop_pending <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // pixel FIFO
  // ---------------------------------------------------------------------------
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push_req = (r_state == CAPTURE) && bus.cmos_frame_href && bus.cmos_frame_clken;
  assign w_wr_en    = !w_empty && (r_state == CAPTURE || r_state == FLUSH);
  assign w_pop      = w_wr_en && bus.wr_ready;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Pixel storage write port.
  always_ff @(posedge cmos_pclk) begin
    // NOTE: the storage array carries no reset; validity is tracked by the
    // reset pointers and count, which keeps the array a plain RAM.
    if (w_push) r_mem[r_wr_ptr] <= bus.cmos_frame_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag for the frame being captured.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_load) r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // frame geometry check
  // ---------------------------------------------------------------------------
`ifdef CMOS_SIZE_CHECK_EN
  localparam int PIX_W  = $clog2(IMG_HDISP + 2);
  localparam int LINE_W = $clog2(IMG_VDISP + 2);

  logic              r_href_d;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic [LINE_W-1:0] r_line_cnt;
  logic              r_geo_err;
  logic              w_href_fall;

  assign w_href_fall = r_href_d && !bus.cmos_frame_href;

  // Count pixels per line and lines per frame; both saturate one past the
  // nominal size so an overlong line or frame can never wrap back to "good".
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      r_href_d   <= 1'b0;
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
      r_geo_err  <= 1'b0;
    end else begin
      r_href_d <= bus.cmos_frame_href;
      if (w_load) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
        r_geo_err  <= 1'b0;
      end else if (r_state == CAPTURE) begin
        if (w_push_req && r_pix_cnt <= PIX_W'(IMG_HDISP)) begin
          r_pix_cnt <= r_pix_cnt + 1'b1;
        end
        if (w_href_fall) begin
          if (r_pix_cnt != PIX_W'(IMG_HDISP)) r_geo_err <= 1'b1;
          r_pix_cnt <= '0;
          if (r_line_cnt <= LINE_W'(IMG_VDISP)) r_line_cnt <= r_line_cnt + 1'b1;
        end
      end
    end
  end

  assign w_geo_bad = r_geo_err || (r_line_cnt != LINE_W'(IMG_VDISP));
`else
  assign w_geo_bad = 1'b0;
`endif

  assign w_good = !r_ovf && !w_geo_bad;

  // ---------------------------------------------------------------------------
  // write address and frame commit
  // ---------------------------------------------------------------------------

  // Reload the bank base at frame start; advance once per accepted write.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst)         r_wr_addr <= '0;
    else if (w_load) r_wr_addr <= r_wbank ? ADDR_W'(FRAME_PIX) : '0;
    else if (w_pop)  r_wr_addr <= r_wr_addr + 1'b1;
  end

  // Commit or discard the finished frame; pulses coincide with FLUSH exit.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      r_wbank      <= 1'b0;
      r_disp_bank  <= 1'b0;
      r_disp_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_eval) begin
        if (w_good) begin
          r_disp_bank  <= r_wbank;
          r_disp_valid <= 1'b1;
          r_wbank      <= ~r_wbank;
          r_frame_done <= 1'b1;
        end else begin
          r_frame_err  <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // outputs
  // ---------------------------------------------------------------------------
  assign bus.wr_en      = w_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  // The head slot cannot change while the write is stalled, so the data
  // stays stable until accepted; idle reads as zero.
  assign bus.wr_data    = w_wr_en ? r_mem[r_rd_ptr] : 16'h0000;
  assign bus.disp_bank  = r_disp_bank;
  assign bus.disp_valid = r_disp_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_cmos_frame_buf_ctrl.sv
// tb_cmos_frame_buf_ctrl
// Randomised frames are issued by the stimulus process; a frame-level
// reference model pushes the expected writes and frame outcomes into queues,
// and an independent monitor pops and compares them as the DUT presents them.
// A 16-entry FIFO is used so a stalled 8x4 frame can overflow it.

module tb_cmos_frame_buf_ctrl;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int AW    = 24;
  localparam int FD    = 16;
  localparam int FRAME = H * V;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmos_frame_buf_ctrl_if #(.ADDR_W(AW)) bus ();

  cmos_frame_buf_ctrl #(
    .IMG_HDISP (H),
    .IMG_VDISP (V),
    .ADDR_W    (AW),
    .FIFO_DEPTH(FD)
  ) dut (
    .cmos_pclk(clk),
    .rst      (rst),
    .bus      (bus)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    bit good;
    bit bank;
    bit valid;
    bit stop;
  } res_t;

  wr_t  exp_q[$];
  res_t res_q[$];

  // frame-level reference model
  bit m_armed, m_wbank, m_disp_bank, m_disp_valid;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 stalled

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // write-port back-pressure
  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.wr_ready = 1'b1;
        2:       bus.wr_ready = 1'b0;
        default: bus.wr_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    bit          hold_pend = 1'b0;
    logic [63:0] hold_addr, hold_data;
    wr_t         w;
    res_t        r;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend && bus.wr_en) begin
          check("hold_addr", bus.wr_addr, hold_addr);
          check("hold_data", bus.wr_data, hold_data);
        end
        hold_pend = bus.wr_en && !bus.wr_ready;
        hold_addr = bus.wr_addr;
        hold_data = bus.wr_data;

        if (bus.wr_en && bus.wr_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", bus.wr_en, 0);
          end else begin
            w = exp_q.pop_front();
            check("wr_addr", bus.wr_addr, w.addr);
            check("wr_data", bus.wr_data, w.data);
          end
        end

        if (bus.frame_done || bus.frame_err) begin
          if (res_q.size() == 0) begin
            check("unexpected_frame_pulse", {bus.frame_done, bus.frame_err}, 0);
          end else begin
            r = res_q.pop_front();
            check("frame_done", bus.frame_done, r.good);
            check("frame_err", bus.frame_err, !r.good);
            check("disp_bank", bus.disp_bank, r.bank);
            check("disp_valid", bus.disp_valid, r.valid);
            check("busy_at_pulse", bus.busy, !r.stop);
          end
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || res_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    check("drain_pending", exp_q.size() + res_q.size(), 0);
  endtask

  task automatic pulse_start();
    bus.cap_start = 1'b1;
    tick();
    bus.cap_start = 1'b0;
    m_armed = 1'b1;
    repeat (2) tick();
  endtask

  // One frame: V lines of H pixels (line short_line carries H-1).
  task automatic drive_frame(input int short_line, input bit stall, input bit start_mid,
                             input bit stop_mid, input bit rnd);
    logic [15:0] px[$];
    int  k, keep, n_l, saved_mode;
    bit  cap, good;
    for (int l = 0; l < V; l++) begin
      n_l = (l == short_line) ? H - 1 : H;
      for (int p = 0; p < n_l; p++) px.push_back(16'($urandom));
    end
    cap  = m_armed;
    good = !(stall && px.size() > FD);
`ifdef CMOS_SIZE_CHECK_EN
    if (short_line >= 0) good = 1'b0;
`endif
    if (cap) begin
      // A stall over the whole frame keeps only the first FD pixels.
      keep = (stall && px.size() > FD) ? FD : px.size();
      for (int i = 0; i < keep; i++)
        exp_q.push_back('{addr: int'(m_wbank) * FRAME + i, data: int'(px[i])});
      if (good) begin
        m_disp_bank  = m_wbank;
        m_disp_valid = 1'b1;
        m_wbank      = ~m_wbank;
      end
      res_q.push_back('{good: good, bank: m_disp_bank, valid: m_disp_valid, stop: stop_mid});
      if (stop_mid) m_armed = 1'b0;
    end

    bus.cmos_frame_vsync = 1'b0;
    repeat (4) tick();
    saved_mode = rdy_mode;
    if (stall) rdy_mode = 2;
    bus.cmos_frame_vsync = 1'b1;
    repeat (3) tick();
    k = 0;
    for (int l = 0; l < V; l++) begin
      n_l = (l == short_line) ? H - 1 : H;
      bus.cmos_frame_href = 1'b1;
      for (int p = 0; p < n_l; p++) begin
        while (rnd && $urandom_range(1) == 1) tick();
        bus.cmos_frame_data  = px[k];
        bus.cmos_frame_clken = 1'b1;
        k++;
        tick();
        bus.cmos_frame_clken = 1'b0;
      end
      bus.cmos_frame_href = 1'b0;
      if (l == 1) begin
        bus.cap_start = start_mid;
        bus.cap_stop  = stop_mid;
        if (start_mid) m_armed = 1'b1;
      end
      tick();
      bus.cap_start = 1'b0;
      bus.cap_stop  = 1'b0;
      tick();
    end
    rdy_mode = saved_mode;
    repeat (2) tick();
    bus.cmos_frame_vsync = 1'b0;
    tick();
    wait_drain(400);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},      bus.wr_en, 0);
    check({tag, "_wr_addr"},    bus.wr_addr, 0);
    check({tag, "_wr_data"},    bus.wr_data, 0);
    check({tag, "_disp_bank"},  bus.disp_bank, 0);
    check({tag, "_disp_valid"}, bus.disp_valid, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_frame_err"},  bus.frame_err, 0);
    check({tag, "_busy"},       bus.busy, 0);
  endtask

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // stimulus
  initial begin
    rst                  = 1'b1;
    bus.cap_start        = 1'b0;
    bus.cap_stop         = 1'b0;
    bus.cmos_frame_vsync = 1'b0;
    bus.cmos_frame_href  = 1'b0;
    bus.cmos_frame_clken = 1'b0;
    bus.cmos_frame_data  = '0;
    {m_armed, m_wbank, m_disp_bank, m_disp_valid} = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // arm mid-frame: that frame is skipped, then two frames fill both banks
    drive_frame(-1, 0, 1, 0, 0);
    drive_frame(-1, 0, 0, 0, 0);
    drive_frame(-1, 0, 0, 0, 0);

    // random pixel gaps and write back-pressure
    rdy_mode = 1;
    repeat (3) drive_frame(-1, 0, 0, 0, 1);
    rdy_mode = 0;

    // overflow frame, then a good frame at the same bank base
    drive_frame(-1, 1, 0, 0, 0);
    drive_frame(-1, 0, 0, 0, 0);

    // one short line
    drive_frame(1, 0, 0, 0, 0);

    // stop mid-capture, then a frame that must not be captured
    drive_frame(-1, 0, 0, 1, 0);
    drive_frame(-1, 0, 0, 0, 0);
    check("busy_after_stop", bus.busy, 0);

    // reset in the middle of a frame
    pulse_start();
    bus.cmos_frame_vsync = 1'b1;
    repeat (3) tick();
    bus.cmos_frame_href = 1'b1;
    for (int i = 0; i < H; i++) begin
      bus.cmos_frame_data  = 16'($urandom);
      bus.cmos_frame_clken = 1'b1;
      exp_q.push_back('{addr: int'(m_wbank) * FRAME + i, data: int'(bus.cmos_frame_data)});
      tick();
    end
    bus.cmos_frame_clken = 1'b0;
    bus.cmos_frame_href  = 1'b0;
    repeat (4) tick();
    check("pre_reset_writes_left", exp_q.size(), 0);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    exp_q.delete();
    res_q.delete();
    {m_armed, m_wbank, m_disp_bank, m_disp_valid} = '0;
    tick();
    rst = 1'b0;
    bus.cmos_frame_href = 1'b1;
    for (int i = 0; i < H; i++) begin
      bus.cmos_frame_clken = 1'b1;
      tick();
    end
    bus.cmos_frame_clken = 1'b0;
    bus.cmos_frame_href  = 1'b0;
    tick();
    bus.cmos_frame_vsync = 1'b0;
    check("busy_after_reset", bus.busy, 0);
    drive_frame(-1, 0, 0, 0, 0);
    pulse_start();
    drive_frame(-1, 0, 0, 0, 0);

    repeat (5) tick();
    check("final_write_queue", exp_q.size(), 0);
    check("final_result_queue", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
